// File: rtl/falu_wb_pkg.sv
// falu_wb_pkg: FALU opcode encoding, writeback entry type and destination classification
package falu_wb_pkg;
  localparam int WB_RD_W = 5;
  localparam logic [3:0] FALU_ADD     = 4'h0;
  localparam logic [3:0] FALU_SUB     = 4'h1;
  localparam logic [3:0] FALU_MUL     = 4'h2;
  localparam logic [3:0] FALU_DIV     = 4'h3;
  localparam logic [3:0] FALU_MIN     = 4'h4;
  localparam logic [3:0] FALU_MAX     = 4'h5;
  localparam logic [3:0] FALU_SGNJ    = 4'h6;
  localparam logic [3:0] FALU_EQ      = 4'h7;
  localparam logic [3:0] FALU_SLT     = 4'h8;
  localparam logic [3:0] FALU_FCVT_WS = 4'h9;
  localparam logic [3:0] FALU_FCVT_SW = 4'hA;
  typedef struct packed {
    logic               is_int;
    logic [WB_RD_W-1:0] rd;
    logic [31:0]        data;
  } wb_entry_t;
  function automatic logic is_int_dest(input logic [3:0] op);
    return op inside {FALU_EQ, FALU_SLT, FALU_FCVT_WS};
  endfunction
  function automatic logic is_cmp_op(input logic [3:0] op);
    return op inside {FALU_EQ, FALU_SLT};
  endfunction
endpackage

// File: rtl/falu_wb_buffer_if.sv
// falu_wb_buffer_if: ALU result input and float/int writeback ports of the writeback buffer
interface falu_wb_buffer_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [31:0]     in_result;
  logic            in_cmp;
  logic [RD_W-1:0] in_rd;
  logic            fwb_valid;
  logic            fwb_ready;
  logic [RD_W-1:0] fwb_rd;
  logic [31:0]     fwb_data;
  logic            iwb_valid;
  logic            iwb_ready;
  logic [RD_W-1:0] iwb_rd;
  logic [31:0]     iwb_data;
  modport master (
    output in_valid, in_op, in_result, in_cmp, in_rd, fwb_ready, iwb_ready,
    input  in_ready, fwb_valid, fwb_rd, fwb_data, iwb_valid, iwb_rd, iwb_data
  );
  modport slave (
    input  in_valid, in_op, in_result, in_cmp, in_rd, fwb_ready, iwb_ready,
    output in_ready, fwb_valid, fwb_rd, fwb_data, iwb_valid, iwb_rd, iwb_data
  );
endinterface

// File: rtl/falu_wb_fifo.sv
// falu_wb_fifo: DEPTH-entry synchronous FIFO with push/pop/flush and occupancy count
module falu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 38
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  // pointers wrap naturally since DEPTH is a power of two; flush outranks push/pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // storage is not reset; entries beyond count are never observed
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= wdata;
  assign rdata = mem[rptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/falu_wb_buffer.sv
// falu_wb_buffer: in-order FALU writeback buffer routing each result to the float or int port (FALU_WB_BYPASS_EN adds a zero-latency path when empty)
module falu_wb_buffer
  import falu_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RD_W = WB_RD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  falu_wb_buffer_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  wb_entry_t in_e, head, out_e;
  logic push, pop, full, empty, bypass, out_v;
  assign in_e = {is_int_dest(bus.in_op), bus.in_rd,
                 is_cmp_op(bus.in_op) ? {31'b0, bus.in_cmp} : bus.in_result};
`ifdef FALU_WB_BYPASS_EN
  assign bypass = empty & bus.in_valid & !flush & (in_e.is_int ? bus.iwb_ready : bus.fwb_ready);
`else
  assign bypass = 1'b0;
`endif
  assign pop          = !empty & (head.is_int ? bus.iwb_ready : bus.fwb_ready);
  assign bus.in_ready = !full | pop;
  assign push         = bus.in_valid & bus.in_ready & !bypass;
  // present the bypassed input or the stored head; rd/data read as zero while nothing is presented
  always_comb begin
    out_e = bypass ? in_e : head;
    out_v = bypass | !empty;
    bus.fwb_valid = out_v & !out_e.is_int;
    bus.iwb_valid = out_v & out_e.is_int;
    bus.fwb_rd    = out_v ? out_e.rd : '0;
    bus.iwb_rd    = out_v ? out_e.rd : '0;
    bus.fwb_data  = out_v ? out_e.data : '0;
    bus.iwb_data  = out_v ? out_e.data : '0;
  end
  falu_wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_e),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_falu_wb_buffer.sv
// tb_falu_wb_buffer: directed and randomized checks of falu_wb_buffer against a queue model
module tb_falu_wb_buffer;
  import falu_wb_pkg::*;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic        is_int;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  logic clk, rst_n, flush;
  logic [2:0] count;
  int total, bad;
  ent_t q[$];
  falu_wb_buffer_if #(.RD_W(5)) bus ();
  falu_wb_buffer #(.DEPTH(DEPTH), .RD_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic ent_t mk(input logic [3:0] op, input logic [31:0] res, input logic cmp, input logic [4:0] rd);
    ent_t e;
    e.is_int = (op == FALU_EQ) || (op == FALU_SLT) || (op == FALU_FCVT_WS);
    e.rd = rd;
    e.data = ((op == FALU_EQ) || (op == FALU_SLT)) ? {31'b0, cmp} : res;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] res, input logic cmp, input logic [4:0] rd);
    bus.in_valid = v;
    bus.in_op = op;
    bus.in_result = res;
    bus.in_cmp = cmp;
    bus.in_rd = rd;
  endtask

  task automatic test_reset;
    #3;
    total++; if (bus.fwb_valid !== 1'b0) begin bad++; $display("FAIL reset_fwb_valid got=%b want=0", bus.fwb_valid); end
    total++; if (bus.iwb_valid !== 1'b0) begin bad++; $display("FAIL reset_iwb_valid got=%b want=0", bus.iwb_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if ({bus.fwb_rd, bus.fwb_data, bus.iwb_rd, bus.iwb_data} !== 74'd0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", {bus.fwb_rd, bus.fwb_data, bus.iwb_rd, bus.iwb_data}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_float;
    @(negedge clk);
    bus.fwb_ready = 1'b0;
    drive(1'b1, FALU_ADD, 32'h40400000, 1'b0, 5'd3);
    #1;
    total++; if (bus.fwb_valid !== 1'b0) begin bad++; $display("FAIL float_latency got=%b want=0", bus.fwb_valid); end
    @(negedge clk);
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    bus.fwb_ready = 1'b1;
    #1;
    total++; if ({bus.fwb_valid, bus.fwb_rd, bus.fwb_data} !== {1'b1, 5'd3, 32'h40400000}) begin bad++; $display("FAIL float_out got=%h want=%h", {bus.fwb_valid, bus.fwb_rd, bus.fwb_data}, {1'b1, 5'd3, 32'h40400000}); end
    total++; if (bus.iwb_valid !== 1'b0) begin bad++; $display("FAIL float_iwb_quiet got=%b want=0", bus.iwb_valid); end
    @(negedge clk);
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL float_drained got=%0d want=0", count); end
  endtask

  task automatic test_int;
    @(negedge clk);
    bus.iwb_ready = 1'b0;
    drive(1'b1, FALU_EQ, 32'h1, 1'b1, 5'd7);
    @(negedge clk);
    bus.iwb_ready = 1'b1;
    drive(1'b1, FALU_SLT, 32'hFFFFFFFF, 1'b0, 5'd9);
    #1;
    total++; if ({bus.iwb_valid, bus.fwb_valid, bus.iwb_rd, bus.iwb_data} !== {2'b10, 5'd7, 32'h1}) begin bad++; $display("FAIL int_feq got=%h want=%h", {bus.iwb_valid, bus.fwb_valid, bus.iwb_rd, bus.iwb_data}, {2'b10, 5'd7, 32'h1}); end
    @(negedge clk);
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    #1;
    total++; if ({bus.iwb_valid, bus.fwb_valid, bus.iwb_rd, bus.iwb_data} !== {2'b10, 5'd9, 32'h0}) begin bad++; $display("FAIL int_fslt got=%h want=%h", {bus.iwb_valid, bus.fwb_valid, bus.iwb_rd, bus.iwb_data}, {2'b10, 5'd9, 32'h0}); end
    @(negedge clk);
  endtask

  task automatic test_full;
    bus.fwb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, FALU_MUL, 32'h1000 + i, 1'b0, 5'(i));
    end
    @(negedge clk);
    drive(1'b1, FALU_MUL, 32'h1004, 1'b0, 5'd4);
    #1;
    total++; if ({count, bus.in_ready} !== {3'd4, 1'b0}) begin bad++; $display("FAIL full_state got=%h want=%h", {count, bus.in_ready}, {3'd4, 1'b0}); end
    @(negedge clk);
    bus.fwb_ready = 1'b1;
    #1;
    total++; if ({bus.in_ready, bus.fwb_data} !== {1'b1, 32'h1000}) begin bad++; $display("FAIL full_pop_frees got=%h want=%h", {bus.in_ready, bus.fwb_data}, {1'b1, 32'h1000}); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, FALU_MUL, 32'h1004 + k, 1'b0, 5'(4 + k));
      #1;
      total++; if ({count, bus.fwb_data} !== {3'd4, 32'h1000 + k}) begin bad++; $display("FAIL full_pushpop got=%h want=%h", {count, bus.fwb_data}, {3'd4, 32'h1000 + k}); end
    end
    @(negedge clk);
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    for (int k = 4; k < 8; k++) begin
      #1;
      total++; if ({bus.fwb_valid, bus.fwb_rd, bus.fwb_data} !== {1'b1, 5'(k), 32'h1000 + k}) begin bad++; $display("FAIL full_drain got=%h want=%h", {bus.fwb_valid, bus.fwb_rd, bus.fwb_data}, {1'b1, 5'(k), 32'h1000 + k}); end
      @(negedge clk);
    end
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL full_empty got=%0d want=0", count); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    bus.fwb_ready = 1'b1;
    bus.iwb_ready = 1'b0;
    drive(1'b1, FALU_FCVT_WS, 32'h55, 1'b0, 5'd2);
    @(negedge clk);
    drive(1'b1, FALU_ADD, 32'h66, 1'b0, 5'd4);
    @(negedge clk);
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({count, bus.fwb_valid, bus.iwb_valid, bus.iwb_data} !== {3'd2, 2'b01, 32'h55}) begin bad++; $display("FAIL stall_blocked got=%h want=%h", {count, bus.fwb_valid, bus.iwb_valid, bus.iwb_data}, {3'd2, 2'b01, 32'h55}); end
      @(negedge clk);
    end
    bus.iwb_ready = 1'b1;
    @(negedge clk);
    #1;
    total++; if ({bus.fwb_valid, bus.iwb_valid, bus.fwb_rd, bus.fwb_data} !== {2'b10, 5'd4, 32'h66}) begin bad++; $display("FAIL stall_next got=%h want=%h", {bus.fwb_valid, bus.iwb_valid, bus.fwb_rd, bus.fwb_data}, {2'b10, 5'd4, 32'h66}); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    bus.fwb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, FALU_SUB, 32'hA0 + i, 1'b0, 5'(i));
    end
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, FALU_SUB, 32'hBB, 1'b0, 5'd11);
    #1;
    total++; if ({count, bus.in_ready} !== {3'd3, 1'b1}) begin bad++; $display("FAIL flush_pre got=%h want=%h", {count, bus.in_ready}, {3'd3, 1'b1}); end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    #1;
    total++; if ({count, bus.fwb_valid, bus.iwb_valid} !== 5'd0) begin bad++; $display("FAIL flush_clear got=%h want=0", {count, bus.fwb_valid, bus.iwb_valid}); end
    @(negedge clk);
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_drop got=%0d want=0", count); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, FALU_DIV, 32'hC0 + i, 1'b0, 5'(i));
    end
    @(negedge clk);
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    #1;
    total++; if ({count, bus.fwb_valid} !== {3'd2, 1'b1}) begin bad++; $display("FAIL areset_pre got=%h want=%h", {count, bus.fwb_valid}, {3'd2, 1'b1}); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({count, bus.fwb_valid, bus.iwb_valid, bus.in_ready} !== {3'd0, 3'b001}) begin bad++; $display("FAIL areset_now got=%h want=%h", {count, bus.fwb_valid, bus.iwb_valid, bus.in_ready}, {3'd0, 3'b001}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef FALU_WB_BYPASS_EN
  task automatic test_bypass;
    @(negedge clk);
    bus.fwb_ready = 1'b1;
    drive(1'b1, FALU_ADD, 32'h3F800000, 1'b0, 5'd5);
    #1;
    total++; if ({bus.fwb_valid, bus.iwb_valid, bus.fwb_rd, bus.fwb_data} !== {2'b10, 5'd5, 32'h3F800000}) begin bad++; $display("FAIL bypass_out got=%h want=%h", {bus.fwb_valid, bus.iwb_valid, bus.fwb_rd, bus.fwb_data}, {2'b10, 5'd5, 32'h3F800000}); end
    @(negedge clk);
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    #1;
    total++; if ({count, bus.fwb_valid} !== 4'd0) begin bad++; $display("FAIL bypass_nostore got=%h want=0", {count, bus.fwb_valid}); end
  endtask
`endif

  task automatic test_random;
    ent_t e, h;
    logic byp, hv, pop, push, exp_ready;
    logic [79:0] got, want;
    q.delete();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive($urandom_range(1, 0) == 1, 4'($urandom_range(15, 0)), $urandom, $urandom_range(1, 0) == 1, 5'($urandom_range(31, 0)));
      bus.fwb_ready = $urandom_range(9, 0) < 7;
      bus.iwb_ready = $urandom_range(9, 0) < 6;
      flush = $urandom_range(29, 0) == 0;
      #1;
      e = mk(bus.in_op, bus.in_result, bus.in_cmp, bus.in_rd);
      byp = 1'b0;
`ifdef FALU_WB_BYPASS_EN
      byp = q.size() == 0 && bus.in_valid && !flush && (e.is_int ? bus.iwb_ready : bus.fwb_ready);
`endif
      hv = byp || q.size() > 0;
      h = byp ? e : (q.size() > 0 ? q[0] : '0);
      pop = q.size() > 0 && (q[0].is_int ? bus.iwb_ready : bus.fwb_ready);
      exp_ready = q.size() < DEPTH || pop;
      push = bus.in_valid && exp_ready && !byp;
      want = {hv && !h.is_int, hv && h.is_int, exp_ready, 3'(q.size()),
              hv ? {h.rd, h.data, h.rd, h.data} : 74'd0};
      got = {bus.fwb_valid, bus.iwb_valid, bus.in_ready, count,
             (bus.fwb_valid || bus.iwb_valid) ? {bus.fwb_rd, bus.fwb_data, bus.iwb_rd, bus.iwb_data} : 74'd0};
      total++; if (got !== want) begin bad++; $display("FAIL random[%0d] got=%h want=%h", n, got, want); end
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.fwb_ready = 1'b0;
    bus.iwb_ready = 1'b0;
    drive(1'b0, FALU_ADD, 32'h0, 1'b0, 5'd0);
    test_reset;
    test_float;
    test_int;
    test_full;
    test_stall;
    test_flush;
    test_async_reset;
`ifdef FALU_WB_BYPASS_EN
    test_bypass;
`endif
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/falu_wb_buffer.md
Name: falu_wb_buffer

Overview:
- Writeback buffer directly downstream of the combinational floating-point ALU. Captures each ALU result with its destination tag.
- Classifies each result as float-register or integer-register writeback: FEQ/FSLT/FCVT.W.S write the integer file, everything else writes the float file.
- Drains results in order through two valid/ready writeback ports, decoupling ALU issue from register-file port contention.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, >= 2.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  buffer can accept this cycle.
- in_op  input  4  ALU opcode (`FALU_* encoding).
- in_result  input  32  ALU result.
- in_cmp  input  1  ALU compare flag.
- in_rd  input  RD_W  destination register.
- fwb_valid  output  1  float writeback valid.
- fwb_ready  input  1  float register file accepts.
- fwb_rd  output  RD_W  float destination.
- fwb_data  output  32  float data.
- iwb_valid  output  1  integer writeback valid.
- iwb_ready  input  1  integer register file accepts.
- iwb_rd  output  RD_W  integer destination.
- iwb_data  output  32  integer data.
- count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read/write pointers and count go to 0; storage need not be cleared.
  - All valids go to 0, in_ready to 1, rd/data outputs to 0.
- Enqueue:
  - Occurs when in_valid & in_ready on a rising edge.
  - in_ready = (count != DEPTH) | dequeue-this-cycle. Pop-when-full frees a slot in the same cycle.
- Entry contents at enqueue: {is_int, rd, data}.
  - is_int = in_op is `FALU_EQ, `FALU_SLT or `FALU_FCVT_WS.
  - data = {31'b0, in_cmp} for `FALU_EQ/`FALU_SLT; otherwise in_result.
- Head routing (outputs registered from storage, no combinational path from in_*):
  - fwb_valid = !empty & !head.is_int.
  - iwb_valid = !empty & head.is_int.
  - Never both valid. rd/data on both ports mirror the head entry.
- Dequeue: occurs when the active port's valid & ready. In-order only; a blocked head stalls younger entries even if they target the other port.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Enqueue into empty buffer: entry appears at head the following cycle (min latency 1 cycle).
- Pointers wrap modulo DEPTH. count saturates by construction; no overflow or underflow is possible because in_ready and valid gate both operations.
- flush:
  - Next edge: count=0, pointers=0, valids low.
  - Has priority over a simultaneous enqueue or dequeue; a same-cycle input is dropped.
  - in_ready is still 1 during flush.
- Valid/data hold: a presented output valid and its data stay stable until accepted or flushed.

Optional Feature:
- Macro: FALU_WB_BYPASS_EN.
- Defined: when the buffer is empty and the incoming entry's target port is ready, in_* drives the target port combinationally in the same cycle and nothing is stored (latency 0). If the port is not ready, the entry is enqueued as normal. While bypassing, the non-target port's valid is 0.
- Undefined: no combinational in-to-out path; latency is always >= 1.

Decomposition:
- Package falu_wb_pkg:
  - typedef wb_entry_t {logic is_int; logic [RD_W-1:0] rd; logic [31:0] data}.
  - function is_int_dest(op).
  - Opcode values taken from the existing `FALU_* defines.
- Sub-module falu_wb_fifo: generic DEPTH-entry synchronous FIFO with push/pop/flush, full/empty/count. The top level adds classification, routing and bypass.

Test Plan:
- FADD result 0x40400000, rd=3, fwb_ready=1 -> next cycle fwb_valid=1, fwb_rd=3, fwb_data=0x40400000; iwb_valid=0.
- FEQ with in_cmp=1, in_result=1, rd=7 -> iwb_data=0x00000001, iwb_rd=7; FSLT in_cmp=0 -> iwb_data=0.
- fwb_ready=0, push 4 entries -> count=4, in_ready=0. Fifth push is held; raising fwb_ready drains in order with a 1-per-cycle push/pop and count stays at 4.
- Head is an FCVT_WS (int) with iwb_ready=0 and the next entry is float with fwb_ready=1 -> nothing dequeues; fwb_valid=0 until the head drains.
- count=3, flush asserted with simultaneous in_valid -> next cycle count=0, both valids 0; the input is not stored.
- Reset asserted mid-drain (asynchronous, between edges) -> valids drop immediately, count=0. With FALU_WB_BYPASS_EN on an empty buffer and ready port -> same-cycle fwb_valid with data 0x3F800000.
